// File: rtl/fifo_rd_unpacker_if.sv
// fifo_rd_unpacker_if: FIFO show-ahead read port plus narrow beat stream; out_par exists only with FIFO_RD_UNPACKER_PARITY_EN
interface fifo_rd_unpacker_if #(
    parameter int IN_WIDTH  = 140,
    parameter int OUT_WIDTH = 35
);
    logic                 fifo_rdempty;
    logic [IN_WIDTH-1:0]  fifo_rddata;
    logic                 fifo_rden;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
`ifdef FIFO_RD_UNPACKER_PARITY_EN
    logic                 out_par;
    modport master (
        input  fifo_rdempty, fifo_rddata, out_ready,
        output fifo_rden, out_valid, out_data, out_last, out_par
    );
    modport slave (
        output fifo_rdempty, fifo_rddata, out_ready,
        input  fifo_rden, out_valid, out_data, out_last, out_par
    );
`else
    modport master (
        input  fifo_rdempty, fifo_rddata, out_ready,
        output fifo_rden, out_valid, out_data, out_last
    );
    modport slave (
        output fifo_rdempty, fifo_rddata, out_ready,
        input  fifo_rden, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker: pops wide show-ahead FIFO words and streams them as RATIO narrow beats, LSB slice first
// Optional even parity on each beat via FIFO_RD_UNPACKER_PARITY_EN.
module fifo_rd_unpacker #(
    parameter int IN_WIDTH  = 140,
    parameter int OUT_WIDTH = 35
) (
    input  logic rdclk,
    input  logic rdrst,
    input  logic flush,
    output logic busy,
    fifo_rd_unpacker_if.master bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW    = $clog2(RATIO);

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t               state;
    logic [IN_WIDTH-1:0]  hold_reg;
    logic [BW-1:0]        beat_idx;
    logic [OUT_WIDTH-1:0] slice [RATIO];
    logic                 valid, at_last, accept, last_acc, pop;

    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign slice[i] = hold_reg[i*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        valid    = (state == SHIFT);
        at_last  = (beat_idx == BW'(RATIO-1));
        accept   = valid & bus.out_ready;
        last_acc = accept & at_last;
        pop      = !rdrst & !flush & !bus.fifo_rdempty & (!valid | last_acc);
    end

    // flush outranks accept and pop; a finished word with no successor parks at index 0
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            state    <= EMPTY;
            beat_idx <= '0;
            hold_reg <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            beat_idx <= '0;
        end else if (pop) begin
            state    <= SHIFT;
            beat_idx <= '0;
            hold_reg <= bus.fifo_rddata;
        end else if (last_acc) begin
            state    <= EMPTY;
            beat_idx <= '0;
        end else if (accept) begin
            beat_idx <= beat_idx + 1'b1;
        end
    end

    assign bus.fifo_rden = pop;
    assign bus.out_valid = valid;
    assign bus.out_data  = slice[beat_idx];
    assign bus.out_last  = valid & at_last;
    assign busy          = valid;
`ifdef FIFO_RD_UNPACKER_PARITY_EN
    assign bus.out_par   = ^bus.out_data;
`endif
endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb_fifo_rd_unpacker: random FIFO/backpressure/flush/reset traffic checked against a queue-of-beats model
module tb_fifo_rd_unpacker;
    localparam int IW = 140;
    localparam int OW = 35;
    localparam int R  = IW / OW;

    logic rdclk = 1'b0;
    logic rdrst, flush, busy, after_rst;
    int   passed = 0;
    int   total  = 0;

    logic [IW-1:0] fifo_q [$];
    logic [OW-1:0] cur [$];

    fifo_rd_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .rdclk (rdclk),
        .rdrst (rdrst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.master)
    );

    always #5 rdclk = ~rdclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycle(input int p_ready, input int p_flush, input int p_rst);
        logic [IW-1:0] w, t;
        logic [63:0]   r;
        logic          exp_rden;
        @(negedge rdclk);
        if (fifo_q.size() < 4 && $urandom_range(99) < 60) begin
            w = '0;
            for (int i = 0; i < R; i++) begin
                r = {$urandom, $urandom};
                w = w | (IW'(r[OW-1:0]) << (i*OW));
            end
            fifo_q.push_back(w);
        end
        bus.fifo_rdempty = fifo_q.size() == 0 || $urandom_range(3) == 0;
        bus.fifo_rddata  = fifo_q.size() != 0 ? fifo_q[0] : '0;
        bus.out_ready    = $urandom_range(99) < p_ready;
        flush            = $urandom_range(99) < p_flush;
        rdrst            = $urandom_range(99) < p_rst;
        #1;
        exp_rden = !rdrst && !flush && !bus.fifo_rdempty &&
                   (cur.size() == 0 || (bus.out_ready && cur.size() == 1));
        chk("out_valid", 64'(bus.out_valid), 64'(cur.size() != 0));
        chk("busy", 64'(busy), 64'(cur.size() != 0));
        chk("fifo_rden", 64'(bus.fifo_rden), 64'(exp_rden));
        if (cur.size() != 0) begin
            chk("out_data", 64'(bus.out_data), 64'(cur[0]));
            chk("out_last", 64'(bus.out_last), 64'(cur.size() == 1));
`ifdef FIFO_RD_UNPACKER_PARITY_EN
            chk("out_par", 64'(bus.out_par), 64'(^cur[0]));
`endif
        end else begin
            chk("out_last_idle", 64'(bus.out_last), 64'(0));
        end
        if (after_rst) begin
            chk("out_data_rst", 64'(bus.out_data), 64'(0));
`ifdef FIFO_RD_UNPACKER_PARITY_EN
            chk("out_par_rst", 64'(bus.out_par), 64'(0));
`endif
        end
        @(posedge rdclk);
        after_rst = rdrst;
        if (rdrst || flush) cur.delete();
        else begin
            if (bus.out_ready && cur.size() != 0) void'(cur.pop_front());
            if (exp_rden) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < R; i++) begin
                    t = w >> (i*OW);
                    cur.push_back(t[OW-1:0]);
                end
            end
        end
    endtask

    initial begin
        rdrst            = 1'b1;
        flush            = 1'b0;
        after_rst        = 1'b1;
        bus.fifo_rdempty = 1'b1;
        bus.fifo_rddata  = '0;
        bus.out_ready    = 1'b0;
        repeat (2) @(posedge rdclk);
        repeat (300) cycle(100, 0, 0);
        repeat (600) cycle(50, 0, 0);
        repeat (600) cycle(70, 10, 0);
        repeat (600) cycle(70, 5, 3);
        repeat (400) cycle(100, 3, 2);
        repeat (300) cycle(20, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
